seq_div4: RTL



---
 rtl/seq_div4.sv | 93 +++++++++
 1 files changed

// File: rtl/seq_div4.sv
// Sequential restoring divider: one quotient bit per cycle from a single
// WIDTH+1-bit trial subtractor; results land WIDTH cycles after start.
module seq_div4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is taken on any edge where busy = 0; done is a one-cycle
  // pulse that is never back-pressured or acknowledged.
  logic [1:0]       state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic             last_iter;

  // A restored partial remainder is always below the divisor, so its top bit
  // is zero between iterations; only the shifted value needs WIDTH+1 bits.
  always_comb begin
    r_shift   = {r_r, q_r[WIDTH-1]};
    trial     = r_shift - {1'b0, d_r};
    q_next    = {q_r[WIDTH-2:0], 1'b0};
    r_next    = r_shift[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      q_next = {q_r[WIDTH-2:0], 1'b1};
      r_next = trial[WIDTH-1:0];
    end
    last_iter = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      q_r         <= '0;
      d_r         <= '0;
      r_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            q_r   <= dividend;
            d_r   <= divisor;
            r_r   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          q_r <= q_next;
          r_r <= r_next;
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= (d_r == '0);
            state       <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule
